jtframe_mister_ddr_dump: RTL and testbench



---
 rtl/jtframe_mister_ddr_dump_pkg.sv | 31 +++
 rtl/jtframe_dual_ram.sv | 39 +++
 rtl/jtframe_mister_ddr_dump.sv | 272 +++++++++++++++++++++++++++
 tb/tb_jtframe_mister_ddr_dump.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_mister_ddr_dump_pkg.sv
// Shared definitions for the core-memory to MiSTer DDR3 dump uploader.
//   DDR_BASE  : top nibble of the 29-bit DDRAM word address (window 0x3000_0000)
//   BW_DEF    : default log2 of words per burst
//   TOUT_DEF  : default width of the core-read timeout counter
//   state_t   : controller state encoding
//   be_mask() : byte-enable mask for the final beat of a dump
package jtframe_mister_ddr_dump_pkg;

    localparam logic [3:0] DDR_BASE = 4'd3;
    localparam int         BW_DEF   = 7;
    localparam int         TOUT_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Lanes holding valid bytes in a word that carries rem bytes (0 means all 8).
    function automatic logic [7:0] be_mask(input logic [2:0] rem);
        logic [7:0] mask;
        if (rem == 3'd0) begin
            mask = 8'hFF;
        end else begin
            mask = (8'd1 << rem) - 8'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with one cycle of latency.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset of the read data register only
//   we0, addr0, data0 : write port
//   re1, addr1        : read port enable and address
//   q1                : registered read data (holds while re1 is low)
module jtframe_dual_ram #(
    parameter int dw = 64,
    parameter int aw = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we0,
    input  logic [aw-1:0] addr0,
    input  logic [dw-1:0] data0,
    input  logic          re1,
    input  logic [aw-1:0] addr1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem_r [0:(2**aw)-1];

    // Write port: storage array, no reset.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[addr0] <= data0;
        end
    end

    // Read port: registered output, cleared by reset so the DDR data bus starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
        end else if (re1) begin
            q1 <= mem_r[addr1];
        end
    end

endmodule

// File: rtl/jtframe_mister_ddr_dump.sv
// Uploader from a core-side byte memory into the MiSTer DDR3 window at 0x3000_0000.
// Bytes are read one at a time, packed little-endian into 64-bit words, buffered
// (2^BW words) and flushed as DDRAM write bursts, one page of 2^BW words per burst.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, len              : one-cycle request and byte count (ignored while busy)
//   busy, done, err         : status; err is sticky until the next start
//   dump_addr, dump_rd      : core read address/strobe
//   dump_din, dump_ok       : core read data/acknowledge
//   ddram_busy              : DDRAM wait request
//   ddram_we, ddram_addr, ddram_burstcnt, ddram_din, ddram_be : DDRAM write burst
//   chksum                  : 16-bit running byte sum (only with JTFRAME_DDRDUMP_CHKSUM_EN)
//
// Build option: define JTFRAME_DDRDUMP_CHKSUM_EN to add the chksum port and its adder.
module jtframe_mister_ddr_dump
    import jtframe_mister_ddr_dump_pkg::*;
#(
    parameter int BW   = BW_DEF,
    parameter int TOUT = TOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [26:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [26:0] dump_addr,
    output logic        dump_rd,
    input  logic [7:0]  dump_din,
    input  logic        dump_ok,
    input  logic        ddram_busy,
    output logic        ddram_we,
    output logic [28:0] ddram_addr,
    output logic [7:0]  ddram_burstcnt,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be
`ifdef JTFRAME_DDRDUMP_CHKSUM_EN
    ,
    output logic [15:0] chksum
`endif
);

    localparam int             PAGEW     = 29 - 4 - BW;
    localparam logic [BW:0]    WCNT_LAST = {1'b0, {BW{1'b1}}};
    localparam logic [BW:0]    WCNT_ONE  = {{BW{1'b0}}, 1'b1};
    localparam logic [BW-1:0]  BEAT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [TOUT-1:0] TOUT_ONE = {{(TOUT-1){1'b0}}, 1'b1};
    localparam logic [PAGEW-1:0] PAGE_ONE = {{(PAGEW-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nx_s;
    logic [26:0]      len_r;
    logic [PAGEW-1:0] page_r;
    logic [BW:0]      wcnt_r;      // words buffered in the current page
    logic [BW-1:0]    beat_r;      // index of the beat currently presented
    logic [TOUT-1:0]  tout_r;
    logic [63:0]      pack_r;

    logic             busy_nx_s;
    logic             done_nx_s;
    logic             tout_hit_s;
    logic             take_s;
    logic [7:0]       byte_s;
    logic [2:0]       lane_s;
    logic             last_byte_s;
    logic             word_wr_s;
    logic             fill_end_s;
    logic [63:0]      lane_byte_s;
    logic [63:0]      pack_nx_s;
    logic             accept_s;
    logic             last_beat_s;
    logic             last_burst_s;
    logic             more_s;
    logic [BW-1:0]    next_beat_s;
    logic             nxt_last_s;
    logic [7:0]       be_nx_s;
    logic             rd_en_s;
    logic [BW-1:0]    rd_addr_s;

    // ---------------- fill side ----------------
    // A byte is taken on acknowledge, or as 0xFF once the wait counter saturates.
    assign tout_hit_s  = (tout_r == {TOUT{1'b1}});
    assign take_s      = (state_r == ST_FILL) && dump_rd && (dump_ok || tout_hit_s);
    assign byte_s      = dump_ok ? dump_din : 8'hFF;
    assign lane_s      = dump_addr[2:0];
    assign last_byte_s = ((dump_addr + 27'd1) == len_r);
    assign word_wr_s   = take_s && ((lane_s == 3'd7) || last_byte_s);
    assign fill_end_s  = word_wr_s && ((wcnt_r == WCNT_LAST) || last_byte_s);
    // Lane 0 restarts the word, so lanes past the last byte of a dump stay zero.
    assign lane_byte_s = {56'd0, byte_s} << {lane_s, 3'b000};
    assign pack_nx_s   = ((lane_s == 3'd0) ? 64'd0 : pack_r) | lane_byte_s;

    // ---------------- write side ----------------
    assign accept_s     = ddram_we && !ddram_busy;
    assign last_beat_s  = accept_s && ((8'(beat_r) + 8'd1) == ddram_burstcnt);
    assign last_burst_s = (dump_addr == len_r);
    assign more_s       = (dump_addr != len_r);
    assign next_beat_s  = beat_r + BEAT_ONE;
    // Index of the beat that will be presented next: 0 at prefetch, else beat_r+1.
    assign nxt_last_s   = ((ddram_we ? (8'(beat_r) + 8'd2) : 8'd1) == ddram_burstcnt);
    assign be_nx_s      = (nxt_last_s && last_burst_s) ? be_mask(len_r[2:0]) : 8'hFF;
    // The RAM output always holds the presented beat; it advances on acceptance so
    // the following beat is ready one cycle later without a bubble.
    assign rd_en_s      = (state_r == ST_WRITE) && !last_beat_s;
    assign rd_addr_s    = !ddram_we ? {BW{1'b0}} : (accept_s ? next_beat_s : beat_r);

    jtframe_dual_ram #(
        .dw (64),
        .aw (BW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we0   (word_wr_s),
        .addr0 (dump_addr[BW+2:3]),
        .data0 (pack_nx_s),
        .re1   (rd_en_s),
        .addr1 (rd_addr_s),
        .q1    (ddram_din)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = (len != 27'd0) ? ST_FILL : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_end_s) begin
                    state_nx_s = ST_WRITE;
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (last_beat_s) begin
                    state_nx_s = more_s ? ST_FILL : ST_DONE;
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so busy/done are registered.
    always_comb begin
        busy_nx_s = (state_nx_s == ST_FILL) || (state_nx_s == ST_WRITE);
        done_nx_s = (state_nx_s == ST_DONE);
    end

    // Status output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx_s;
            done <= done_nx_s;
        end
    end

    // Datapath: core reads, packing, burst control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r          <= 27'd0;
            err            <= 1'b0;
            page_r         <= {PAGEW{1'b0}};
            dump_addr      <= 27'd0;
            dump_rd        <= 1'b0;
            wcnt_r         <= {(BW+1){1'b0}};
            beat_r         <= {BW{1'b0}};
            tout_r         <= {TOUT{1'b0}};
            pack_r         <= 64'd0;
            ddram_we       <= 1'b0;
            ddram_addr     <= 29'd0;
            ddram_burstcnt <= 8'd0;
            ddram_be       <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r     <= len;
                        err       <= 1'b0;
                        page_r    <= {PAGEW{1'b0}};
                        dump_addr <= 27'd0;
                        wcnt_r    <= {(BW+1){1'b0}};
                        tout_r    <= {TOUT{1'b0}};
                        pack_r    <= 64'd0;
                    end
                end
                ST_FILL: begin
                    // Strobe drops for one cycle after each byte, then rises again.
                    dump_rd <= !take_s;
                    tout_r  <= (take_s || !dump_rd) ? {TOUT{1'b0}} : (tout_r + TOUT_ONE);
                    if (take_s) begin
                        dump_addr <= dump_addr + 27'd1;
                        pack_r    <= pack_nx_s;
                        if (!dump_ok) begin
                            err <= 1'b1;
                        end
                    end
                    if (word_wr_s) begin
                        wcnt_r <= wcnt_r + WCNT_ONE;
                    end
                    if (fill_end_s) begin
                        ddram_addr     <= {DDR_BASE, page_r, {BW{1'b0}}};
                        ddram_burstcnt <= 8'(wcnt_r) + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (!ddram_we) begin
                        // Prefetch cycle: beat 0 lands in the RAM output at this edge.
                        ddram_we <= 1'b1;
                        beat_r   <= {BW{1'b0}};
                        ddram_be <= be_nx_s;
                    end else if (accept_s) begin
                        if (last_beat_s) begin
                            ddram_we <= 1'b0;
                            ddram_be <= 8'd0;
                            page_r   <= page_r + PAGE_ONE;
                            wcnt_r   <= {(BW+1){1'b0}};
                        end else begin
                            beat_r   <= next_beat_s;
                            ddram_be <= be_nx_s;
                        end
                    end
                end
                ST_DONE: begin
                    dump_rd <= 1'b0;
                end
                default: begin
                    dump_rd <= 1'b0;
                end
            endcase
        end
    end

`ifdef JTFRAME_DDRDUMP_CHKSUM_EN
    // Running 16-bit sum of every byte taken, timeout bytes included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum <= 16'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            chksum <= 16'd0;
        end else if (take_s) begin
            chksum <= chksum + {8'd0, byte_s};
        end
    end
`endif

endmodule

// File: tb/tb_jtframe_mister_ddr_dump.sv
// Scoreboard bench for jtframe_mister_ddr_dump: a reference model expands each
// dump request into the expected DDR beats; a monitor compares every accepted beat.
module tb_jtframe_mister_ddr_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [26:0] len;
    logic        busy;
    logic        done;
    logic        err;
    logic [26:0] dump_addr;
    logic        dump_rd;
    logic [7:0]  dump_din;
    logic        dump_ok;
    logic        ddram_busy;
    logic        ddram_we;
    logic [28:0] ddram_addr;
    logic [7:0]  ddram_burstcnt;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
`ifdef JTFRAME_DDRDUMP_CHKSUM_EN
    logic [15:0] chksum;
`endif

    jtframe_mister_ddr_dump dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .dump_addr      (dump_addr),
        .dump_rd        (dump_rd),
        .dump_din       (dump_din),
        .dump_ok        (dump_ok),
        .ddram_busy     (ddram_busy),
        .ddram_we       (ddram_we),
        .ddram_addr     (ddram_addr),
        .ddram_burstcnt (ddram_burstcnt),
        .ddram_din      (ddram_din),
        .ddram_be       (ddram_be)
`ifdef JTFRAME_DDRDUMP_CHKSUM_EN
        ,
        .chksum         (chksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] addr;
        logic [7:0]  cnt;
        logic [63:0] data;
        logic [7:0]  be;
    } beat_t;

    beat_t      sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         rd_cycles = 0;
    int         we_cycles = 0;
    int         beats_seen = 0;
    int         busy_mode = 0;
    int         lat_max = 0;
    int         stall_addr = -1;
    logic [7:0] key = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes -> little-endian words -> 128-word bursts.
    task automatic push_expect(input int L, output logic exp_err, output logic [15:0] exp_sum);
        int nwords;
        nwords  = (L + 7) / 8;
        exp_err = 1'b0;
        exp_sum = 16'd0;
        for (int w = 0; w < nwords; w++) begin
            beat_t e;
            int    burst;
            int    first;
            int    cnt;
            e.data = 64'd0;
            for (int k = 0; k < 8; k++) begin
                int         i;
                logic [7:0] b;
                i = 8 * w + k;
                if (i < L) begin
                    if (i == stall_addr) begin
                        b = 8'hFF;
                        exp_err = 1'b1;
                    end else begin
                        b = 8'(i) ^ key;
                    end
                    e.data[8*k +: 8] = b;
                    exp_sum = exp_sum + {8'd0, b};
                end
            end
            burst  = w / 128;
            first  = burst * 128;
            cnt    = (nwords - first > 128) ? 128 : (nwords - first);
            e.addr = 29'h0600_0000 + 29'(burst * 128);
            e.cnt  = 8'(cnt);
            e.be   = ((w == nwords - 1) && ((L % 8) != 0)) ? 8'((1 << (L % 8)) - 1) : 8'hFF;
            sb.push_back(e);
        end
    endtask

    // Core memory and DDR wait-request model, driven on the falling edge.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        dump_ok    = 1'b0;
        dump_din   = 8'd0;
        ddram_busy = 1'b0;
        forever begin
            @(negedge clk);
            case (busy_mode)
                0:       ddram_busy = 1'b0;
                1:       ddram_busy = ~ddram_busy;
                default: ddram_busy = 1'($urandom_range(0, 1));
            endcase
            if ((dump_rd === 1'b1) && !((stall_addr >= 0) && (dump_addr == 27'(stall_addr)))) begin
                if (wait_cnt == 0) begin
                    dump_ok  = 1'b1;
                    dump_din = dump_addr[7:0] ^ key;
                    wait_cnt = int'($urandom_range(0, lat_max));
                end else begin
                    dump_ok  = 1'b0;
                    wait_cnt = wait_cnt - 1;
                end
            end else begin
                dump_ok = 1'b0;
            end
        end
    end

    // Monitor: compares DDR beats against the scoreboard, counts strobes.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (dump_rd === 1'b1) rd_cycles++;
            if (done === 1'b1) done_cnt++;
            if (ddram_we === 1'b1) begin
                we_cycles++;
                if (sb.size() == 0) begin
                    if (!ddram_busy) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h with no beat expected", ddram_din);
                    end
                end else begin
                    check("ddram_addr", 64'(ddram_addr), 64'(sb[0].addr));
                    check("ddram_burstcnt", 64'(ddram_burstcnt), 64'(sb[0].cnt));
                    if (!ddram_busy) begin
                        check("ddram_din", ddram_din, sb[0].data);
                        check("ddram_be", 64'(ddram_be), 64'(sb[0].be));
                        void'(sb.pop_front());
                        beats_seen++;
                    end
                end
            end
        end
    end

    task automatic run_dump(input int L, input logic [7:0] k, input int mode, input int lat, input int stall);
        logic        exp_err;
        logic [15:0] exp_sum;
        int          d0;
        int          r0;
        int          w0;
        int          cyc;
        key        = k;
        busy_mode  = mode;
        lat_max    = lat;
        stall_addr = stall;
        push_expect(L, exp_err, exp_sum);
        d0 = done_cnt;
        r0 = rd_cycles;
        w0 = we_cycles;
        @(negedge clk);
        start = 1'b1;
        len   = 27'(L);
        @(negedge clk);
        start = 1'b0;
        #2;
        check("busy_after_start", 64'(busy), 64'(L != 0));
        if (L == 0) check("len0_done", 64'(done), 64'd1);
        cyc = 0;
        while ((done_cnt == d0) && (cyc < L * 12 + 2000)) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("busy_at_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #2;
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("err", 64'(err), 64'(exp_err));
`ifdef JTFRAME_DDRDUMP_CHKSUM_EN
        check("chksum", 64'(chksum), 64'(exp_sum));
`endif
        if (L == 0) begin
            check("len0_no_rd", 64'(rd_cycles - r0), 64'd0);
            check("len0_no_we", 64'(we_cycles - w0), 64'd0);
        end
        sb.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_dump_rd"}, 64'(dump_rd), 64'd0);
        check({tag, "_ddram_we"}, 64'(ddram_we), 64'd0);
        check({tag, "_dump_addr"}, 64'(dump_addr), 64'd0);
        check({tag, "_burstcnt"}, 64'(ddram_burstcnt), 64'd0);
        check({tag, "_be"}, 64'(ddram_be), 64'd0);
        check({tag, "_din"}, ddram_din, 64'd0);
`ifdef JTFRAME_DDRDUMP_CHKSUM_EN
        check({tag, "_chksum"}, 64'(chksum), 64'd0);
`endif
    endtask

    // Global time limit.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic        dummy_err;
        logic [15:0] dummy_sum;
        int          b0;
        int          cyc;
        rst_n = 1'b0;
        start = 1'b0;
        len   = 27'd0;
        repeat (3) @(negedge clk);
        #2;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_dump(16, 8'd0, 0, 0, -1);
        run_dump(1027, 8'd0, 0, 1, -1);
        run_dump(64, 8'd0, 1, 0, -1);
        run_dump(0, 8'd0, 0, 0, -1);
        run_dump(8, 8'd0, 0, 0, 3);
        for (int t = 0; t < 4; t++) begin
            int L;
            int st;
            L  = int'($urandom_range(1, 700));
            st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            run_dump(L, 8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), st);
        end

        // Reset while beat 5 of a full 128-beat burst is presented.
        key = 8'd0; busy_mode = 0; lat_max = 0; stall_addr = -1;
        push_expect(1024, dummy_err, dummy_sum);
        b0 = beats_seen;
        @(negedge clk);
        start = 1'b1;
        len   = 27'd1024;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while ((beats_seen < b0 + 5) && (cyc < 20000)) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        check("reached_beat5", 64'(beats_seen - b0), 64'd5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_dump(8, 8'd0, 0, 0, -1);
`ifdef JTFRAME_DDRDUMP_CHKSUM_EN
        check("chksum_after_reset", 64'(chksum), 64'h1C);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
